// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles 16-bit words (high byte first) into the
// instruction-memory write port and holds the CPU in reset until the load completes.
// Optional checksum byte after the program: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [15:0] HALT_WORD   = 16'hF000,
    parameter bit          APPEND_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_TERM  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_DONE  = 3'd5,
        S_CSUM  = 3'd6,
        S_ERR   = 3'd7
`else
        S_DONE  = 3'd5
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic        in_ready_q, in_ready_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic        error_q, error_d;
`endif

    logic hs;
    logic restart;
    logic last_word;

    assign hs        = in_valid && in_ready_q;
    // n_q == 0 encodes 256 words, so the final index wraps to 8'hFF
    assign last_word = (cnt_q == (n_q - 8'd1));

    always_comb begin
        restart = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: restart = start;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_ERR:          restart = start;
`endif
            default:        restart = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        error_d   = error_q;
`endif

        if (restart) begin
            state_d   = S_COUNT;
            busy_d    = 1'b1;
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            error_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (hs) begin
                        n_d     = in_data;
                        cnt_d   = 8'd0;
                        state_d = S_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d  = in_data;
`endif
                    end
                end
                S_HI: begin
                    if (hs) begin
                        hi_d    = in_data;
                        state_d = S_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d  = csum_q ^ in_data;
`endif
                    end
                end
                S_LO: begin
                    if (hs) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q;
                        wr_data_d = {hi_q, in_data};
                        cnt_d     = cnt_q + 8'd1;
                        state_d   = last_word ? S_TERM : S_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d    = csum_q ^ in_data;
`endif
                    end
                end
                S_TERM: begin
                    if (APPEND_HALT && (n_q != 8'd0)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = n_q;
                        wr_data_d = HALT_WORD;
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end
                S_DONE: begin
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    cpu_rst_d = 1'b0;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    // status is updated on the checksum handshake itself
                    if (hs) begin
                        busy_d = 1'b0;
                        if (in_data == csum_q) begin
                            state_d   = S_DONE;
                            done_d    = 1'b1;
                            cpu_rst_d = 1'b0;
                        end else begin
                            state_d   = S_ERR;
                            error_d   = 1'b1;
                            cpu_rst_d = 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    cpu_rst_d = 1'b1;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end

        case (state_d)
            S_COUNT, S_HI, S_LO: in_ready_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:              in_ready_d = 1'b1;
`endif
            default:             in_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= 8'd0;
            cnt_q      <= 8'd0;
            hi_q       <= 8'd0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 16'd0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            error_q    <= error_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_rst  = cpu_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign error    = error_q;
`else
    assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a word-list model predicts the write sequence,
// HALT append, completion latency and final status of every load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [15:0] words [256];
    logic [23:0] got_q [$];
    logic [23:0] exp_q [$];

    always @(negedge clk) begin
        if (rst_n && wr_en) got_q.push_back({wr_addr, wr_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // gap_mode: 0 none, 1 random idle cycles, 2 one idle cycle before every byte
    task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit pulse);
        int guard;
        if (pulse && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            start    = 1'b1;
            @(negedge clk);
            start    = 1'b0;
        end
        if (gap_mode == 2) begin
            in_valid = 1'b0;
            @(negedge clk);
        end else if (gap_mode == 1) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                check("byte_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        if (gap_mode != 0) in_valid = 1'b0;
    endtask

    task automatic fill_random(input int nw);
        for (int i = 0; i < nw; i++) words[i] = 16'($urandom);
    endtask

    task automatic run_load(input string name, input int nw, input int gap_mode,
                            input bit pulse, input bit bad_csum);
        logic [7:0] cnt_byte;
        logic [7:0] csum;
        int         lat;
        int         exp_lat;
        bit         expect_ok;
        cnt_byte = 8'(nw);
        csum     = cnt_byte;
        exp_q.delete();
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back({8'(i), words[i]});
            csum = csum ^ words[i][15:8] ^ words[i][7:0];
        end
        if (nw != 256) exp_q.push_back({8'(nw), 16'hF000});
        expect_ok = 1'b1;

        got_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
        check({name, "_cpurst_rise"}, {31'd0, cpu_rst}, 32'd1);
        check({name, "_done_clr"}, {31'd0, done}, 32'd0);

        send_byte(cnt_byte, gap_mode, 1'b0);
        for (int i = 0; i < nw; i++) begin
            send_byte(words[i][15:8], gap_mode, pulse);
            send_byte(words[i][7:0], gap_mode, pulse);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (bad_csum) expect_ok = 1'b0;
        send_byte(bad_csum ? ~csum : csum, gap_mode, 1'b0);
        in_valid = 1'b0;
        exp_lat  = 1;
`else
        in_valid = 1'b0;
        exp_lat  = 3;
`endif
        lat = 1;
        while (!(done || error) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        repeat (2) @(negedge clk);

        check({name, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_write"}, {8'd0, got_q[i]}, {8'd0, exp_q[i]});
        check({name, "_done"}, {31'd0, done}, {31'd0, expect_ok});
        check({name, "_error"}, {31'd0, error}, {31'd0, !expect_ok});
        check({name, "_cpurst"}, {31'd0, cpu_rst}, {31'd0, !expect_ok});
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_inready"}, {31'd0, in_ready}, 32'd0);
        if (bad_csum) csum = 8'd0;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({name, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({name, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
        check({name, "_wr_data"}, {16'd0, wr_data}, 32'd0);
        check({name, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        check({name, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        words[0] = 16'h1123;
        words[1] = 16'h2455;
        run_load("dir_b2b", 2, 0, 1'b0, 1'b0);
        run_load("dir_gap", 2, 2, 1'b0, 1'b0);

        fill_random(256);
        run_load("n256", 256, 1, 1'b0, 1'b0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'd4, 0, 1'b0);
        send_byte(8'hA1, 1, 1'b0);
        send_byte(8'hB2, 1, 1'b0);
        send_byte(8'hC3, 1, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        words[0] = 16'h1123;
        words[1] = 16'h2455;
        run_load("reload", 2, 0, 1'b0, 1'b0);

        fill_random(5);
        run_load("pulse", 5, 1, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int nw;
            nw = $urandom_range(1, 20);
            fill_random(nw);
            run_load("rand", nw, $urandom_range(0, 1), ($urandom_range(0, 1) == 1), 1'b0);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        words[0] = 16'h1234;
        run_load("csum_ok", 1, 0, 1'b0, 1'b0);
        run_load("csum_bad", 1, 0, 1'b0, 1'b1);
        fill_random(3);
        run_load("after_err", 3, 1, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
